// File: rtl/imm_decode_seq.sv
// Decode-stage sequencer: classifies the opcode into an immediate format, drives signext,
// and registers instr/PC/immediate toward execute through a two-entry skid buffer.

package signext_pkg;
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
endpackage

module signext #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [24:0]           instr,
    input  logic [2:0]            imm_op,
    output logic [DATA_WIDTH-1:0] imm
);
    import signext_pkg::*;

    // instr holds word bits [31:7], so word bit k sits at index k-7
    logic signed [31:0] u_imm;
    assign u_imm = {instr[24:5], 12'b0};

    always_comb begin
        imm = '0;
        case (imm_op)
            IMM_I:   imm = {{(DATA_WIDTH-12){instr[24]}}, instr[24:13]};
            IMM_S:   imm = {{(DATA_WIDTH-12){instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:   imm = {{(DATA_WIDTH-12){instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_U:   imm = DATA_WIDTH'(u_imm);
            IMM_J:   imm = {{(DATA_WIDTH-20){instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

module imm_decode_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic                  out_has_imm,
    output logic                  out_illegal,
    output logic [15:0]           illegal_count
);
    import signext_pkg::*;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
    state_t state;

    logic [2:0]            imm_op_p0;
    logic                  has_imm_p0;
    logic                  illegal_p0;
    logic [DATA_WIDTH-1:0] imm_p0;

    logic [31:0]           skid_instr;
    logic [DATA_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0] skid_imm;
    logic                  skid_has_imm;
    logic                  skid_illegal;

    logic accept;
    logic deliver;

    always_comb begin
        imm_op_p0  = IMM_NONE;
        has_imm_p0 = 1'b1;
        illegal_p0 = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: imm_op_p0 = IMM_I;
            7'b0100011:             imm_op_p0 = IMM_S;
            7'b1100011:             imm_op_p0 = IMM_B;
            7'b0110111, 7'b0010111: imm_op_p0 = IMM_U;
            7'b1101111:             imm_op_p0 = IMM_J;
            7'b0110011:             has_imm_p0 = 1'b0;
            default: begin
                has_imm_p0 = 1'b0;
                illegal_p0 = 1'b1;
            end
        endcase
    end

    signext #(.DATA_WIDTH(DATA_WIDTH)) u_signext (
        .instr  (in_instr[31:7]),
        .imm_op (imm_op_p0),
        .imm    (imm_p0)
    );

    // in_ready depends only on registered state (plus reset), never on out_ready
    assign in_ready  = rst_n && (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    // ---- stage p1: output register and skid register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_EMPTY;
            out_instr     <= '0;
            out_pc        <= '0;
            out_imm       <= '0;
            out_has_imm   <= 1'b0;
            out_illegal   <= 1'b0;
            skid_instr    <= '0;
            skid_pc       <= '0;
            skid_imm      <= '0;
            skid_has_imm  <= 1'b0;
            skid_illegal  <= 1'b0;
            illegal_count <= '0;
        end else begin
            if (deliver && out_illegal && (illegal_count != 16'hFFFF))
                illegal_count <= illegal_count + 16'd1;

            if (flush) begin
                state <= S_EMPTY;
            end else begin
                case (state)
                    S_EMPTY: begin
                        if (accept) begin
                            out_instr   <= in_instr;
                            out_pc      <= in_pc;
                            out_imm     <= imm_p0;
                            out_has_imm <= has_imm_p0;
                            out_illegal <= illegal_p0;
                            state       <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (accept && deliver) begin
                            out_instr   <= in_instr;
                            out_pc      <= in_pc;
                            out_imm     <= imm_p0;
                            out_has_imm <= has_imm_p0;
                            out_illegal <= illegal_p0;
                        end else if (accept) begin
                            skid_instr   <= in_instr;
                            skid_pc      <= in_pc;
                            skid_imm     <= imm_p0;
                            skid_has_imm <= has_imm_p0;
                            skid_illegal <= illegal_p0;
                            state        <= S_TWO;
                        end else if (deliver) begin
                            state <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (deliver) begin
                            out_instr   <= skid_instr;
                            out_pc      <= skid_pc;
                            out_imm     <= skid_imm;
                            out_has_imm <= skid_has_imm;
                            out_illegal <= skid_illegal;
                            state       <= S_ONE;
                        end
                    end
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end
endmodule
